// File: rtl/flash_bus_master_pkg.sv
// Shared types and constants for the flash bus master slice.
// Holds the controller state encoding, parameter defaults and RV32 opcodes.
package flash_bus_master_pkg;

    localparam int DEFAULT_READ_LAT = 3;
    localparam int DEFAULT_ADDR_W   = 24;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;
    localparam logic [6:0] OPCODE_OP    = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        STORE = 2'd3
    } state_t;

endpackage

// File: rtl/flash_bus_master_ir_assembler.sv
// Byte-lane shadow register that collects instruction bytes during a fetch.
// Writes one 8-bit lane per strobe; clear wins over write.
module ir_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [1:0]  lane,
    input  logic [7:0]  wr_byte,
    output logic [31:0] word
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word <= '0;
        end else if (clear) begin
            word <= '0;
        end else if (wr_en) begin
            word[{lane, 3'b000} +: 8] <= wr_byte;
        end
    end

endmodule

// File: rtl/flash_bus_master.sv
// Flash bus master: serialises 32-bit instruction fetches, byte loads and
// byte stores onto a byte-wide flash port with a fixed read latency.
module flash_bus_master
    import flash_bus_master_pkg::*;
#(
    parameter int READ_LAT = DEFAULT_READ_LAT,
    parameter int ADDR_W   = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              ld_req,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [7:0]        st_data,
    output logic              busy,
    output logic [31:0]       ir,
    output logic              ir_valid,
    output logic [7:0]        ld_data,
    output logic              ld_valid,
    output logic              st_done,
    output logic              flash_re,
    output logic              flash_we,
    output logic [ADDR_W-1:0] flash_addr,
    output logic [7:0]        flash_in,
    input  logic [7:0]        flash_out
);

    state_t      state;
    logic [2:0]  lat_cnt;
    logic [1:0]  byte_cnt;
    logic        lat_done;
    logic [31:0] asm_word;
    logic [31:0] fetch_word;

    assign busy     = (state != IDLE);
    assign lat_done = (lat_cnt == 3'(READ_LAT - 1));

    // The last byte bypasses the shadow so ir can be loaded on the final edge.
    always_comb begin
        fetch_word        = asm_word;
        fetch_word[31:24] = flash_out;
    end

    ir_assembler u_ir_assembler (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == IDLE),
        .wr_en   ((state == FETCH) && lat_done),
        .lane    (byte_cnt),
        .wr_byte (flash_out),
        .word    (asm_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            byte_cnt   <= '0;
            ir         <= '0;
            ir_valid   <= 1'b0;
            ld_data    <= '0;
            ld_valid   <= 1'b0;
            st_done    <= 1'b0;
            flash_re   <= 1'b0;
            flash_we   <= 1'b0;
            flash_addr <= '0;
            flash_in   <= '0;
        end else begin
            ir_valid <= 1'b0;
            ld_valid <= 1'b0;
            st_done  <= 1'b0;
            case (state)
                IDLE: begin
                    lat_cnt  <= '0;
                    byte_cnt <= '0;
                    if (st_req) begin
                        state      <= STORE;
                        flash_we   <= 1'b1;
                        flash_addr <= data_addr;
                        flash_in   <= st_data;
                        st_done    <= 1'b1;
                    end else if (ld_req) begin
                        state      <= LOAD;
                        flash_re   <= 1'b1;
                        flash_addr <= data_addr;
                    end else if (fetch_req) begin
                        state      <= FETCH;
                        flash_re   <= 1'b1;
                        flash_addr <= fetch_addr;
                    end
                end
                FETCH: begin
                    if (lat_done) begin
                        lat_cnt <= '0;
                        if (byte_cnt == 2'd3) begin
                            ir         <= fetch_word;
                            ir_valid   <= 1'b1;
                            state      <= IDLE;
                            flash_re   <= 1'b0;
                            flash_addr <= '0;
                        end else begin
                            byte_cnt   <= byte_cnt + 2'd1;
                            flash_addr <= flash_addr + ADDR_W'(1);
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                LOAD: begin
                    if (lat_done) begin
                        ld_data    <= flash_out;
                        ld_valid   <= 1'b1;
                        state      <= IDLE;
                        flash_re   <= 1'b0;
                        flash_addr <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                STORE: begin
                    state      <= IDLE;
                    flash_we   <= 1'b0;
                    flash_addr <= '0;
                    flash_in   <= '0;
                end
                default: begin
                    state      <= IDLE;
                    flash_re   <= 1'b0;
                    flash_we   <= 1'b0;
                    flash_addr <= '0;
                    flash_in   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_bus_master.sv
// Directed bench for flash_bus_master with a small behavioural flash model.
// Expected values are hand-computed from the preloaded flash contents.
module tb_flash_bus_master;

    localparam int READ_LAT = 3;
    localparam int ADDR_W   = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              ld_req;
    logic              st_req;
    logic [ADDR_W-1:0] data_addr;
    logic [7:0]        st_data;
    logic              busy;
    logic [31:0]       ir;
    logic              ir_valid;
    logic [7:0]        ld_data;
    logic              ld_valid;
    logic              st_done;
    logic              flash_re;
    logic              flash_we;
    logic [ADDR_W-1:0] flash_addr;
    logic [7:0]        flash_in;
    logic [7:0]        flash_out;

    logic [7:0]        mem [128];
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [7:0]        pre_data;

    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    flash_bus_master #(
        .READ_LAT (READ_LAT),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .ld_req     (ld_req),
        .st_req     (st_req),
        .data_addr  (data_addr),
        .st_data    (st_data),
        .busy       (busy),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .st_done    (st_done),
        .flash_re   (flash_re),
        .flash_we   (flash_we),
        .flash_addr (flash_addr),
        .flash_in   (flash_in),
        .flash_out  (flash_out)
    );

    // Sparse flash: the top address bit plus the low six bits select a cell.
    function automatic logic [6:0] mem_index(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1], a[5:0]};
    endfunction

    assign flash_out = mem[mem_index(flash_addr)];

    always @(posedge clk) begin
        if (flash_we)
            mem[mem_index(flash_addr)] <= flash_in;
        else if (pre_we)
            mem[mem_index(pre_addr)] <= pre_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        else
            pass_count++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic f, input logic l, input logic s,
                                 input logic [ADDR_W-1:0] fa,
                                 input logic [ADDR_W-1:0] da,
                                 input logic [7:0] sd);
        fetch_req  = f;
        ld_req     = l;
        st_req     = s;
        fetch_addr = fa;
        data_addr  = da;
        st_data    = sd;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    // Called one step after the accepting edge of a fetch.
    task automatic fetch_body(input logic [ADDR_W-1:0] base, input logic [31:0] exp_ir);
        logic [ADDR_W-1:0] a;
        for (int e = 0; e < 4 * READ_LAT; e++) begin
            a = base + ADDR_W'(e / READ_LAT);
            checkOutput("fetch_addr", flash_addr, a);
            checkOutput("fetch_re", flash_re, 1'b1);
            checkOutput("fetch_busy", busy, 1'b1);
            checkOutput("fetch_no_early_valid", ir_valid, 1'b0);
            tick();
        end
        checkOutput("fetch_ir_valid", ir_valid, 1'b1);
        checkOutput("fetch_ir", ir, exp_ir);
        checkOutput("fetch_idle_busy", busy, 1'b0);
        checkOutput("fetch_idle_re", flash_re, 1'b0);
        checkOutput("fetch_idle_addr", flash_addr, '0);
        tick();
        checkOutput("fetch_valid_pulse", ir_valid, 1'b0);
        checkOutput("fetch_ir_hold", ir, exp_ir);
    endtask

    // Called one step after the accepting edge of a load.
    task automatic load_body(input logic [ADDR_W-1:0] a, input logic [7:0] exp_data);
        for (int e = 0; e < READ_LAT; e++) begin
            checkOutput("load_addr", flash_addr, a);
            checkOutput("load_re", flash_re, 1'b1);
            checkOutput("load_no_early_valid", ld_valid, 1'b0);
            tick();
        end
        checkOutput("load_valid", ld_valid, 1'b1);
        checkOutput("load_data", ld_data, exp_data);
        checkOutput("load_idle_busy", busy, 1'b0);
        tick();
        checkOutput("load_valid_pulse", ld_valid, 1'b0);
        checkOutput("load_data_hold", ld_data, exp_data);
    endtask

    initial begin
        reset  = 1'b1;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 8'h00);
        preload(24'h000000, 8'h83);
        preload(24'h000001, 8'h02);
        preload(24'h000002, 8'h00);
        preload(24'h000003, 8'h02);
        preload(24'h000020, 8'h0A);
        preload(24'h000021, 8'h5A);
        preload(24'h000023, 8'h99);
        preload(24'hFFFFFE, 8'hEF);
        preload(24'hFFFFFF, 8'hBE);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_ir", ir, 32'h0);
        checkOutput("reset_ld_data", ld_data, 8'h00);
        checkOutput("reset_flash_addr", flash_addr, '0);
        checkOutput("reset_flash_re_we", {flash_re, flash_we}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        tick();

        $display("[TB] fetch at 0x000000");
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h000000, '0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 8'h00);
        fetch_body(24'h000000, 32'h02000283);

        $display("[TB] loads at 0x20 and 0x21");
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 24'h000020, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 8'h00);
        load_body(24'h000020, 8'h0A);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 24'h000021, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 8'h00);
        load_body(24'h000021, 8'h5A);

        $display("[TB] store 0x64 to 0x22");
        applyStimulus(1'b0, 1'b0, 1'b1, '0, 24'h000022, 8'h64);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 8'hFF);
        checkOutput("store_we", flash_we, 1'b1);
        checkOutput("store_re", flash_re, 1'b0);
        checkOutput("store_done", st_done, 1'b1);
        checkOutput("store_addr", flash_addr, 24'h000022);
        checkOutput("store_data", flash_in, 8'h64);
        checkOutput("store_busy", busy, 1'b1);
        tick();
        checkOutput("store_we_pulse", flash_we, 1'b0);
        checkOutput("store_done_pulse", st_done, 1'b0);
        checkOutput("store_idle_busy", busy, 1'b0);
        checkOutput("store_ld_data_hold", ld_data, 8'h5A);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 24'h000022, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 8'h00);
        load_body(24'h000022, 8'h64);

        $display("[TB] fetch wrapping past the top of the address space");
        preload(24'h000000, 8'hAD);
        preload(24'h000001, 8'hDE);
        applyStimulus(1'b1, 1'b0, 1'b0, 24'hFFFFFE, '0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 8'h00);
        fetch_body(24'hFFFFFE, 32'hDEADBEEF);

        $display("[TB] simultaneous fetch and load");
        applyStimulus(1'b1, 1'b1, 1'b0, 24'h000020, 24'h000021, 8'h00);
        tick();
        checkOutput("prio_load_first", flash_addr, 24'h000021);
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h000020, '0, 8'h00);
        load_body(24'h000021, 8'h5A);
        checkOutput("prio_fetch_accepted", busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 8'h00);
        fetch_body(24'h000020, 32'h99645A0A);

        $display("[TB] reset during a fetch");
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h000000, '0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 8'h00);
        repeat (4) tick();
        reset = 1'b1;
        #1;
        checkOutput("abort_re", flash_re, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_ir", ir, 32'h0);
        checkOutput("abort_ld_data", ld_data, 8'h00);
        checkOutput("abort_flash_addr", flash_addr, '0);
        repeat (2) begin
            tick();
            checkOutput("abort_no_ir_valid", ir_valid, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h000000, '0, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        tick();
        checkOutput("post_reset_accept", busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 8'h00);
        fetch_body(24'h000000, 32'h0200DEAD);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
